// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: width codes, LSU states,
// and the alignment helper used when LSU_MISALIGN_CHECK_EN is defined.
package lsu_pkg;

  localparam int unsigned WdtTypeCnt = 4;
  localparam int unsigned RegWidth   = 64;
  localparam int unsigned RamAddr    = 64;

  localparam logic [WdtTypeCnt-1:0] Wdt8  = 4'b0001;
  localparam logic [WdtTypeCnt-1:0] Wdt16 = 4'b0010;
  localparam logic [WdtTypeCnt-1:0] Wdt32 = 4'b0100;
  localparam logic [WdtTypeCnt-1:0] Wdt64 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_RD = 2'd1,
    ISSUE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [WdtTypeCnt-1:0] wdt,
                                      input logic [2:0]            lsb);
    case (wdt)
      Wdt16:   misaligned = lsb[0];
      Wdt32:   misaligned = |lsb[1:0];
      Wdt64:   misaligned = |lsb;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-result extension: sign-extends the lane-selected,
// zero-extended memory data to the register width when requested.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = RegWidth,
  parameter int unsigned WDT_W  = WdtTypeCnt
) (
  input  logic [DATA_W-1:0] data,
  input  logic [WDT_W-1:0]  wdt,
  input  logic              sign_en,
  output logic [DATA_W-1:0] data_ext_c
);

  always_comb begin
    data_ext_c = data;
    if (sign_en) begin
      if (wdt == WDT_W'(Wdt8))
        data_ext_c = {{(DATA_W-8){data[7]}}, data[7:0]};
      else if (wdt == WDT_W'(Wdt16))
        data_ext_c = {{(DATA_W-16){data[15]}}, data[15:0]};
      else if (wdt == WDT_W'(Wdt32))
        data_ext_c = {{(DATA_W-32){data[31]}}, data[31:0]};
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding CPU-side initiator for the data-memory port.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = RamAddr,
  parameter int unsigned DATA_W = RegWidth,
  parameter int unsigned WDT_W  = WdtTypeCnt
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic              req_signed,
  input  logic [WDT_W-1:0]  req_wdt,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [WDT_W-1:0]  wdt_op,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic              signed_q, signed_d;
  logic              ld_q, ld_d;
  logic              req_ready_d, resp_valid_d, resp_err_d;
  logic              mem_wen_d, mem_ren_d;
  logic [ADDR_W-1:0] mem_raddr_d, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [WDT_W-1:0]  wdt_op_d;
  logic              bad_req_c;
  logic [DATA_W-1:0] load_ext_c;

  // Requests that complete without touching memory.
`ifdef LSU_MISALIGN_CHECK_EN
  assign bad_req_c = !$onehot(req_wdt) ||
                     misaligned(WdtTypeCnt'(req_wdt), req_addr[2:0]);
`else
  assign bad_req_c = !$onehot(req_wdt);
`endif

  lsu_load_ext #(
    .DATA_W (DATA_W),
    .WDT_W  (WDT_W)
  ) u_load_ext (
    .data       (mem_rdata),
    .wdt        (wdt_q),
    .sign_en    (signed_q),
    .data_ext_c (load_ext_c)
  );

  // Load data flows straight from the registered memory row so it is ready in RESP.
  assign resp_data = (state_q == RESP && ld_q) ? load_ext_c : '0;

  always_comb begin
    state_d     = state_q;
    wdt_d       = wdt_q;
    signed_d    = signed_q;
    ld_d        = ld_q;
    resp_err_d  = resp_err;
    mem_wen_d   = 1'b0;
    mem_ren_d   = 1'b0;
    mem_raddr_d = mem_raddr;
    mem_waddr_d = mem_waddr;
    mem_wdata_d = mem_wdata;
    wdt_op_d    = wdt_op;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          wdt_d      = req_wdt;
          signed_d   = req_signed;
          ld_d       = 1'b0;
          resp_err_d = 1'b0;
          if (bad_req_c) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_wen) begin
            state_d     = ISSUE_WR;
            mem_wen_d   = 1'b1;
            mem_waddr_d = req_addr;
            mem_wdata_d = req_wdata;
            wdt_op_d    = req_wdt;
          end else begin
            state_d     = ISSUE_RD;
            mem_ren_d   = 1'b1;
            mem_raddr_d = req_addr;
            wdt_op_d    = req_wdt;
            ld_d        = 1'b1;
          end
        end
      end
      ISSUE_RD, ISSUE_WR: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d    = IDLE;
          resp_err_d = 1'b0;
          ld_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wdt_q      <= '0;
      signed_q   <= 1'b0;
      ld_q       <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      wdt_op     <= '0;
    end else begin
      state_q    <= state_d;
      wdt_q      <= wdt_d;
      signed_q   <= signed_d;
      ld_q       <= ld_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      mem_wen    <= mem_wen_d;
      mem_ren    <= mem_ren_d;
      mem_raddr  <= mem_raddr_d;
      mem_waddr  <= mem_waddr_d;
      mem_wdata  <= mem_wdata_d;
      wdt_op     <= wdt_op_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a behavioural data memory
// (registered row read, falling-edge byte-lane write).
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [3:0]  req_wdt;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_data;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_wen, mem_ren;
  logic [3:0]  wdt_op;

  int cmp_cnt = 0;
  int bad_cnt = 0;
  int ren_seen = 0;
  int wen_seen = 0;
  int ren_base, wen_base;

  logic [63:0] mem [0:511];
  logic [63:0] row_q;
  logic [63:0] rd_mask;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_signed (req_signed),
    .req_wdt    (req_wdt),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .wdt_op     (wdt_op),
    .mem_rdata  (mem_rdata)
  );

  function automatic int nbytes(input logic [3:0] w);
    case (w)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  // Memory model: row captured on posedge with mem_ren, lane mux combinational.
  always @(posedge clk) begin
    if (mem_ren) row_q <= mem[mem_raddr[11:3]];
    if (mem_ren === 1'b1) ren_seen <= ren_seen + 1;
    if (mem_wen === 1'b1) wen_seen <= wen_seen + 1;
  end

  always @(negedge clk) begin
    if (mem_wen) begin
      for (int b = 0; b < 8; b++)
        if (b >= int'(mem_waddr[2:0]) && b < int'(mem_waddr[2:0]) + nbytes(wdt_op))
          mem[mem_waddr[11:3]][b*8 +: 8] <= mem_wdata[(b - int'(mem_waddr[2:0]))*8 +: 8];
    end
  end

  always_comb begin
    rd_mask = (nbytes(wdt_op) == 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                                    : ((64'h1 << (nbytes(wdt_op) * 8)) - 64'h1);
    mem_rdata = (row_q >> {mem_raddr[2:0], 3'b000}) & rd_mask;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, then wait (bounded) for resp_valid and check the latency.
  task automatic start_op(input string tag, input logic wen, input logic sgn,
                          input logic [3:0] wdt, input logic [63:0] addr,
                          input logic [63:0] wdata, input int exp_lat);
    int n;
    n = 0;
    while (!req_ready && n < 8) begin tick(); n++; end
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    ren_base   = ren_seen;
    wen_base   = wen_seen;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_signed = sgn;
    req_wdt    = wdt;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
    n = 0;
    while (!resp_valid && n < 8) begin tick(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp_data,
                           input logic exp_err, input int exp_ren, input int exp_wen);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
    chk({tag, "_ren_cnt"}, 64'(ren_seen - ren_base), 64'(exp_ren));
    chk({tag, "_wen_cnt"}, 64'(wen_seen - wen_base), 64'(exp_wen));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_signed = 1'b0; req_wdt = 4'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mem_en", {62'd0, mem_wen, mem_ren}, 64'd0);
    chk("rst_mem_raddr", mem_raddr, 64'd0);
    chk("rst_mem_waddr", mem_waddr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_wdt_op", 64'(wdt_op), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    #20 rst_n = 1'b1;
    tick();
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Background fill so misaligned reads see defined bytes.
    start_op("fill", 1'b1, 1'b0, 4'b1000, 64'h8000_0100, 64'h1111_1111_1111_1111, 1);
    finish_op("fill", 64'd0, 1'b0, 0, 1);

    start_op("st32", 1'b1, 1'b0, 4'b0100, 64'h8000_0100, 64'hDEAD_BEEF, 1);
    finish_op("st32", 64'd0, 1'b0, 0, 1);
    start_op("ld32s", 1'b0, 1'b1, 4'b0100, 64'h8000_0100, 64'd0, 1);
    finish_op("ld32s", 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1, 0);
    start_op("ld32u", 1'b0, 1'b0, 4'b0100, 64'h8000_0100, 64'd0, 1);
    finish_op("ld32u", 64'h0000_0000_DEAD_BEEF, 1'b0, 1, 0);

    start_op("st8", 1'b1, 1'b0, 4'b0001, 64'h8000_0104, 64'h80, 1);
    finish_op("st8", 64'd0, 1'b0, 0, 1);
    start_op("ld8s", 1'b0, 1'b1, 4'b0001, 64'h8000_0104, 64'd0, 1);
    finish_op("ld8s", 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 0);
    start_op("ld8u", 1'b0, 1'b0, 4'b0001, 64'h8000_0104, 64'd0, 1);
    finish_op("ld8u", 64'h80, 1'b0, 1, 0);

    start_op("st64", 1'b1, 1'b0, 4'b1000, 64'h8000_0200, 64'h0123_4567_89AB_CDEF, 1);
    finish_op("st64", 64'd0, 1'b0, 0, 1);
    start_op("ld64", 1'b0, 1'b1, 4'b1000, 64'h8000_0200, 64'd0, 1);
    finish_op("ld64", 64'h0123_4567_89AB_CDEF, 1'b0, 1, 0);

    // Backpressure: response and memory side must hold still.
    start_op("bp", 1'b0, 1'b1, 4'b0010, 64'h8000_0102, 64'd0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", resp_data, 64'hFFFF_FFFF_FFFF_DEAD);
      chk("bp_raddr", mem_raddr, 64'h8000_0102);
      chk("bp_wdt_op", 64'(wdt_op), 64'h2);
      chk("bp_ctl", {60'd0, mem_ren, mem_wen, req_ready, resp_valid}, 64'h1);
      tick();
    end
    finish_op("bp", 64'hFFFF_FFFF_FFFF_DEAD, 1'b0, 1, 0);

    start_op("illegal", 1'b0, 1'b1, 4'b0011, 64'h8000_0100, 64'd0, 0);
    finish_op("illegal", 64'd0, 1'b1, 0, 0);

`ifdef LSU_MISALIGN_CHECK_EN
    start_op("mis32", 1'b0, 1'b0, 4'b0100, 64'h8000_0102, 64'd0, 0);
    finish_op("mis32", 64'd0, 1'b1, 0, 0);
`else
    start_op("mis32", 1'b0, 1'b0, 4'b0100, 64'h8000_0102, 64'd0, 1);
    finish_op("mis32", 64'h1180_DEAD, 1'b0, 1, 0);
`endif

    // Reset while the store is being issued, ahead of the memory's falling edge.
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = 1'b1; req_signed = 1'b0; req_wdt = 4'b0100;
    req_addr = 64'h8000_0100; req_wdata = 64'hCAFE_F00D;
    tick();
    req_valid = 1'b0;
    chk("abort_wen_pre", 64'(mem_wen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wen_now", 64'(mem_wen), 64'd0);
    chk("abort_req_ready_rst", 64'(req_ready), 64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("abort_idle", 64'(req_ready), 64'd1);
    chk("abort_resp_valid2", 64'(resp_valid), 64'd0);
    start_op("post_abort", 1'b0, 1'b0, 4'b0100, 64'h8000_0100, 64'd0, 1);
    finish_op("post_abort", 64'h0000_0000_DEAD_BEEF, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit: the CPU-side initiator for the data-memory port.
- Takes one load or store at a time from the execute stage over a valid/ready handshake.
- Drives the memory's read/write address, data, enable and width signals. The memory has a 1-cycle registered read and writes on the falling edge.
- Returns sign- or zero-extended load data, or a store acknowledge, to writeback over a valid/ready handshake.

Parameters:
- ADDR_W, 64, width of request and memory addresses.
- DATA_W, 64, width of data paths (equals RegWidth).
- WDT_W, 4, width of the one-hot access-width code (Wdt8/Wdt16/Wdt32/Wdt64).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_signed  in  1  sign-extend load result.
- req_wdt  in  WDT_W  access width, one-hot.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned in the low bits.
- resp_valid  out  1  response present.
- resp_ready  in  1  writeback accepts the response.
- resp_data  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  access error.
- mem_raddr  out  ADDR_W  memory read address.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wen  out  1  memory write enable.
- mem_ren  out  1  memory read enable.
- wdt_op  out  WDT_W  access width sent to memory.
- mem_rdata  in  DATA_W  memory read data: lane-selected, zero-extended, valid the cycle after mem_ren.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - req_ready=0 during reset, 1 in IDLE after reset.
  - resp_valid=0, resp_err=0, mem_ren=0, mem_wen=0.
  - mem_raddr=0, mem_waddr=0, mem_wdata=0, wdt_op=0, resp_data=0.
  - Reset mid-operation discards the operation. mem_wen falls combinationally with rst_n.
- All memory-side outputs are registered.
- States IDLE, ISSUE_RD, ISSUE_WR, RESP:
  - IDLE: req_ready=1. On req_valid, latch addr/wdata/wdt/signed. Go to ISSUE_WR if req_wen, else ISSUE_RD.
  - ISSUE_RD (1 cycle): mem_ren=1, mem_raddr=addr, wdt_op=wdt. Memory captures the row at the closing posedge. Next state RESP.
  - ISSUE_WR (1 cycle): mem_wen=1, mem_waddr=addr, mem_wdata=wdata, wdt_op=wdt. The memory writes at the falling edge within this cycle. Next state RESP.
  - RESP:
    - resp_valid=1 and mem_ren=mem_wen=0.
    - mem_raddr and wdt_op are held unchanged, because the memory lane mux is combinational on them.
    - Load: resp_data=ext(mem_rdata). Store: resp_data=0.
    - On resp_ready, go to IDLE.
- req_ready=0 outside IDLE. Only one operation is outstanding.
- Latency:
  - Accept edge T, memory access cycle T+1, resp_valid from cycle T+2.
  - Minimum 3 cycles per operation.
- Backpressure: while resp_valid && !resp_ready, resp_data, resp_err and every memory-side output stay stable.
- Extension:
  - Signed: Wdt8 replicates bit 7, Wdt16 bit 15, Wdt32 bit 31; Wdt64 passes through.
  - Unsigned: pass-through. mem_rdata is already zero-extended.
- Illegal width code (not one-hot):
  - Accepted, but no memory access is issued.
  - Goes directly IDLE to RESP with resp_data=0, resp_err=1.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: an access is misaligned when addr is not a multiple of its size (Wdt16: addr[0]; Wdt32: addr[1:0]; Wdt64: addr[2:0]).
  - A misaligned access goes IDLE to RESP with no mem_ren/mem_wen pulse.
  - Response: resp_err=1, resp_data=0.
- Undefined: no alignment check. The access is issued as-is, and resp_err is set only for an illegal width code.

Decomposition:
- Shared defines/package:
  - Wdt8/Wdt16/Wdt32/Wdt64 one-hot encodings, WdtTypeCnt, RegWidth, RamAddr.
  - LSU state enum.
- One combinational sub-module, lsu_load_ext: inputs data, wdt, signed; output extended data.

Test Plan:
- Store Wdt32 0xDEADBEEF to 0x80000100, then load signed Wdt32 from 0x80000100 -> resp_data=0xFFFFFFFFDEADBEEF. Unsigned load -> 0x00000000DEADBEEF. resp_valid rises 2 cycles after each accept.
- Store Wdt8 0x80 to 0x80000104, then load Wdt8 from 0x80000104 -> signed 0xFFFFFFFFFFFFFF80, unsigned 0x80.
- Store Wdt64 0x0123456789ABCDEF to 0x80000200, then load Wdt64 from 0x80000200 -> 0x0123456789ABCDEF, with exactly one mem_wen cycle and one mem_ren cycle.
- Load, then hold resp_ready=0 for 5 cycles -> resp_data, mem_raddr and wdt_op stable; mem_ren=0; req_ready=0 throughout.
- rst_n low during ISSUE_WR before the falling edge -> mem_wen=0 immediately, target word unchanged, state IDLE, resp_valid=0.
- With LSU_MISALIGN_CHECK_EN, load Wdt32 from 0x80000102 -> resp_err=1 and resp_data=0 one cycle after accept, mem_ren never asserted. Without the macro, the same load issues normally with resp_err=0.
